serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial addition controller that time-shares a single external 1-bit full adder across WIDTH cycles to add two WIDTH-bit operands. It latches operands on a start request, presents one bit pair plus the running carry to the full adder each cycle, and shifts the sum bits into a result register. It reports completion with a one-cycle done pulse. It sits between the switch/operand source and the combinational full-adder cell, and the result drives the LEDs.

## Interface
- WIDTH, 8, operand and sum width in bits; WIDTH >= 1.

- clk  input  1  system clock; only clock in the block.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new addition; sampled only in IDLE.
- a  input  WIDTH  operand A; latched on an accepted start.
- b  input  WIDTH  operand B; latched on an accepted start.
- cin  input  1  initial carry-in; latched on an accepted start.
- fa_a  output  1  full-adder input A (current bit of A).
- fa_b  output  1  full-adder input B (current bit of B).
- fa_ci  output  1  full-adder carry-in (running carry).
- fa_s  input  1  full-adder sum; combinational from fa_a, fa_b, fa_ci.
- fa_co  input  1  full-adder carry-out; combinational from fa_a, fa_b, fa_ci.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when sum and cout are updated.
- sum  output  WIDTH  result of the last completed addition.
- cout  output  1  carry-out of the last completed addition.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE, with start=1: latch a, b and cin into shift registers a_sr, b_sr and carry. Clear the bit counter and the sum shift register. Go to RUN.
- IDLE, with start=0: stay in IDLE.
- RUN, every cycle:
  - fa_a=a_sr[0], fa_b=b_sr[0], fa_ci=carry.
  - At the clock edge: shift a_sr and b_sr right by one.
  - Shift fa_s into sum_sr at the MSB, shifting right.
  - carry <= fa_co; counter <= counter+1.
- RUN, on the edge where counter == WIDTH-1: load sum <= {fa_s, sum_sr[WIDTH-1:1]} and cout <= fa_co. Go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- start is ignored in RUN and in DONE. It is not queued.
- In IDLE and DONE: fa_a, fa_b and fa_ci are 0.
- sum and cout hold their value until the next completion. They are never updated by partial results.
- Arithmetic: {cout, sum} = a + b + cin, using modulo-2^(WIDTH+1) unsigned arithmetic.
- The counter width is $clog2(WIDTH+1) bits. The counter never wraps inside a run.
- WIDTH=1: RUN lasts exactly one cycle.

## Timing
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, fa_a=fa_b=fa_ci=0, all internal registers 0.
- Reset takes priority over every other event, including start and a mid-RUN cycle. The operation in progress is abandoned; done is not pulsed and sum/cout are cleared to 0.
- Edge E0: start is accepted. From E0 to E_WIDTH, state=RUN and busy=1.
- Bit k is presented combinationally during the cycle between E_k and E_(k+1).
- Edge E_WIDTH: sum and cout are valid, and done=1 until E_(WIDTH+1). busy=0 during DONE.
- Latency from accepted start to the done pulse is WIDTH+1 edges. Minimum start-to-start spacing is WIDTH+2 cycles.
- busy and done are registered outputs. fa_a, fa_b and fa_ci are driven directly from registers (a_sr[0], b_sr[0], carry), gated by state.

## Test plan
- WIDTH=8; a=0x5A, b=0x3C, cin=0, pulse start -> busy for 8 cycles, done 9 edges after start, sum=0x96, cout=0.
- WIDTH=8; a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
- WIDTH=8; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start held high continuously with new operands during RUN -> second operands ignored; done pulses once; result matches the first operands. A new operation begins only on the first IDLE cycle.
- Reset asserted 4 cycles into a run of 0x12+0x34 -> next edge gives busy=0, done=0, sum=0, cout=0. A fresh start of 0x12+0x34 completes with sum=0x46, cout=0.
- WIDTH=1, exhaustive over all 8 combinations of {a, b, cin} -> {cout, sum} matches the full-adder truth table (e.g. 1+1+1 -> cout=1, sum=1); done follows 2 edges after start.

Source files
------------

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result bus and full-adder cell hookup for the bit-serial adder controller.
interface serial_adder_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             fa_a;
    logic             fa_b;
    logic             fa_ci;
    logic             fa_s;
    logic             fa_co;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    // Controller side
    modport slave (
        input  start, a, b, cin, fa_s, fa_co,
        output fa_a, fa_b, fa_ci, busy, done, sum, cout
    );

    // Operand source / full-adder cell / result consumer side
    modport master (
        output start, a, b, cin, fa_s, fa_co,
        input  fa_a, fa_b, fa_ci, busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: time-shares one external full adder over WIDTH cycles.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_adder_ctrl_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_shift;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;
    logic             last_bit;

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_bit)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Full-adder drive: register bits gated so the cell sees zeros outside RUN
    always_comb begin
        bus.fa_a  = 1'b0;
        bus.fa_b  = 1'b0;
        bus.fa_ci = 1'b0;
        if (state == RUN) begin
            bus.fa_a  = a_sr[0];
            bus.fa_b  = b_sr[0];
            bus.fa_ci = carry;
        end
    end

    // Sum shift register with the new sum bit entering at the MSB
    always_comb begin
        sum_shift            = sum_sr >> 1;
        sum_shift[WIDTH-1]   = bus.fa_s;
    end

    // Registered status flags, aligned with the state they describe
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_nxt == RUN);
            done_q <= (state_nxt == DONE);
        end
    end

    // Operand shifting, carry/counter tracking and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_sr <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr   <= bus.a;
                        b_sr   <= bus.b;
                        carry  <= bus.cin;
                        cnt    <= '0;
                        sum_sr <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= sum_shift;
                    carry  <= bus.fa_co;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        sum_q  <= sum_shift;
                        cout_q <= bus.fa_co;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench: WIDTH=8 and WIDTH=1 controllers against an arithmetic reference.
module tb_serial_adder_ctrl;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_adder_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_adder_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // External full-adder cells
    assign bus8.fa_s  = bus8.fa_a ^ bus8.fa_b ^ bus8.fa_ci;
    assign bus8.fa_co = (bus8.fa_a & bus8.fa_b) | (bus8.fa_ci & (bus8.fa_a ^ bus8.fa_b));
    assign bus1.fa_s  = bus1.fa_a ^ bus1.fa_b ^ bus1.fa_ci;
    assign bus1.fa_co = (bus1.fa_a & bus1.fa_b) | (bus1.fa_ci & (bus1.fa_a ^ bus1.fa_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Carry into bit k of a+b+c
    function automatic logic carry_at(input int unsigned a, input int unsigned b,
                                      input int unsigned c, input int unsigned k);
        int unsigned mask;
        mask = (32'd1 << k) - 32'd1;
        return 1'(((a & mask) + (b & mask) + c) >> k);
    endfunction

    // One WIDTH=8 addition; entered and left just after a falling edge.
    // With hold=1, start stays high and operands keep changing during RUN/DONE.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin, input bit hold);
        int unsigned total;
        total = 32'(a) + 32'(b) + 32'(cin);
        bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("busy8_run", 32'(bus8.busy), 32'd1);
            check("done8_run", 32'(bus8.done), 32'd0);
            check("fa_a8", 32'(bus8.fa_a), 32'(a[k]));
            check("fa_b8", 32'(bus8.fa_b), 32'(b[k]));
            check("fa_ci8", 32'(bus8.fa_ci), 32'(carry_at(a, b, cin, k)));
            if (hold) begin
                bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
            end else begin
                bus8.start = 1'b0;
            end
            @(posedge clk);
        end
        @(negedge clk);
        check("done8", 32'(bus8.done), 32'd1);
        check("busy8_done", 32'(bus8.busy), 32'd0);
        check("sum8", 32'(bus8.sum), total & 32'hFF);
        check("cout8", 32'(bus8.cout), (total >> 8) & 32'd1);
        check("fa_a8_done", 32'({bus8.fa_a, bus8.fa_b, bus8.fa_ci}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("done8_pulse", 32'(bus8.done), 32'd0);
        check("busy8_idle", 32'(bus8.busy), 32'd0);
        check("sum8_hold", 32'(bus8.sum), total & 32'hFF);
    endtask

    initial begin
        logic [2:0] v;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(bus8.busy), 32'd0);
        check("rst_done", 32'(bus8.done), 32'd0);
        check("rst_sum", 32'(bus8.sum), 32'd0);
        check("rst_cout", 32'(bus8.cout), 32'd0);
        check("rst_fa", 32'({bus8.fa_a, bus8.fa_b, bus8.fa_ci}), 32'd0);
        rst = 1'b0;

        // Directed cases
        run8(8'h5A, 8'h3C, 1'b0, 1'b0);
        run8(8'hFF, 8'h01, 1'b0, 1'b0);
        run8(8'hFF, 8'hFF, 1'b1, 1'b0);

        // start held high: second operands ignored, new run starts on the first IDLE cycle
        run8(8'hA7, 8'h6E, 1'b1, 1'b1);
        run8(8'h13, 8'hC4, 1'b0, 1'b0);

        // Reset mid-run abandons the operation and clears the result
        bus8.a = 8'h12; bus8.b = 8'h34; bus8.cin = 1'b0; bus8.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rstrun_busy", 32'(bus8.busy), 32'd0);
        check("rstrun_done", 32'(bus8.done), 32'd0);
        check("rstrun_sum", 32'(bus8.sum), 32'd0);
        check("rstrun_cout", 32'(bus8.cout), 32'd0);
        repeat (12) begin
            @(negedge clk);
            check("rstrun_nodone", 32'(bus8.done), 32'd0);
        end
        run8(8'h12, 8'h34, 1'b0, 1'b0);

        // Randomized operands
        for (int i = 0; i < 24; i++) begin
            run8(8'($urandom), 8'($urandom), 1'($urandom), bit'($urandom_range(0, 3) == 0));
        end
        bus8.start = 1'b0;

        // WIDTH=1 exhaustive full-adder truth table
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            bus1.a = v[2]; bus1.b = v[1]; bus1.cin = v[0]; bus1.start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus1.start = 1'b0;
            check("busy1_run", 32'(bus1.busy), 32'd1);
            check("fa1", 32'({bus1.fa_a, bus1.fa_b, bus1.fa_ci}), 32'(v));
            @(posedge clk);
            @(negedge clk);
            check("done1", 32'(bus1.done), 32'd1);
            check("busy1_done", 32'(bus1.busy), 32'd0);
            check("sum1", 32'({bus1.cout, bus1.sum}), 32'(v[2]) + 32'(v[1]) + 32'(v[0]));
            @(posedge clk);
            @(negedge clk);
            check("done1_pulse", 32'(bus1.done), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
